// File: rtl/multicycle_ctrl_if.sv
// Memory-side handshake between the multicycle controller and instruction/data memory.
// Handshake: the controller raises Mem_Req with Mem_Write, Address_Src, Store_type and Load_type held
// stable; the access completes in the first cycle where Mem_Ready is high alongside Mem_Req.
interface multicycle_ctrl_if;
    logic Mem_Req;
    logic Mem_Write;
    logic Address_Src;
    logic Store_type;
    logic Load_type;
    logic Mem_Ready;

    modport master (
        output Mem_Req,
        output Mem_Write,
        output Address_Src,
        output Store_type,
        output Load_type,
        input  Mem_Ready
    );

    modport slave (
        input  Mem_Req,
        input  Mem_Write,
        input  Address_Src,
        input  Store_type,
        input  Load_type,
        output Mem_Ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the RV32I-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT with
// memory wait states, branch/JAL support, an end-of-program PC and a sticky illegal flag.
module multicycle_ctrl #(
    parameter int PC_W   = 7,
    parameter int END_PC = 84
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [PC_W-1:0]   PC,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic              funct7_5,
    input  logic              Zero,
    multicycle_ctrl_if.master mem,
    output logic              Inst_Write,
    output logic              PC_Write,
    output logic [1:0]        PC_Src,
    output logic [2:0]        Imm_Src,
    output logic [2:0]        Alu_Control,
    output logic              Reg_Write,
    output logic [1:0]        Result_selector,
    output logic              Halt,
    output logic              Illegal,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    logic is_load, is_store, is_opimm, is_op, is_lui, is_branch, is_jal, supported;
    logic at_end, br_taken;
    logic [2:0] imm_dec, alu_dec;

    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_opimm  = (opcode == OP_OPIMM);
    assign is_op     = (opcode == OP_OP);
    assign is_lui    = (opcode == OP_LUI);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign supported = is_load | is_store | is_opimm | is_op | is_lui | is_branch | is_jal;
    assign at_end    = (PC == PC_W'(END_PC));
    // funct3[0] distinguishes BNE from BEQ, so it inverts the sense of Zero.
    assign br_taken  = Zero ^ funct3[0];

    always_comb begin
        imm_dec = 3'd0;
        if (is_store)       imm_dec = 3'd1;
        else if (is_lui)    imm_dec = 3'd2;
        else if (is_branch) imm_dec = 3'd3;
        else if (is_jal)    imm_dec = 3'd4;
    end

    always_comb begin
        alu_dec = 3'd0;
        if (is_opimm || is_op) begin
            case (funct3)
                3'b000:  alu_dec = (is_op && funct7_5) ? 3'd3 : 3'd0;
                3'b111:  alu_dec = 3'd1;
                3'b110:  alu_dec = 3'd4;
                3'b100:  alu_dec = 3'd5;
                3'b010:  alu_dec = 3'd6;
                default: alu_dec = 3'd0;
            endcase
        end else if (is_lui) begin
            alu_dec = 3'd2;
        end else if (is_branch) begin
            alu_dec = 3'd3;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        case (state_q)
            S_FETCH: begin
                if (at_end)             state_d = S_HALT;
                else if (mem.Mem_Ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (!supported) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_load || is_store)              state_d = S_MEM;
                else if (is_opimm || is_op || is_lui) state_d = S_WB;
                else                                  state_d = S_FETCH;
            end
            S_MEM: begin
                if (mem.Mem_Ready) state_d = is_store ? S_FETCH : S_WB;
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    logic mem_req, mem_write, addr_src, store_type, load_type;

    // Everything is gated by RST_N so a reset mid-access drops the request without a clock edge.
    always_comb begin
        mem_req         = 1'b0;
        mem_write       = 1'b0;
        addr_src        = 1'b0;
        store_type      = 1'b0;
        load_type       = 1'b0;
        Inst_Write      = 1'b0;
        PC_Write        = 1'b0;
        PC_Src          = 2'd0;
        Imm_Src         = 3'd0;
        Alu_Control     = 3'd0;
        Reg_Write       = 1'b0;
        Result_selector = 2'd0;
        Halt            = 1'b0;
        Illegal         = 1'b0;
        if (RST_N) begin
            Illegal = illegal_q;
            case (state_q)
                S_FETCH: begin
                    if (!at_end) begin
                        mem_req = 1'b1;
                        if (mem.Mem_Ready) begin
                            Inst_Write = 1'b1;
                            PC_Write   = 1'b1;
                        end
                    end
                end
                S_DECODE: Imm_Src = imm_dec;
                S_EXEC: begin
                    Imm_Src     = imm_dec;
                    Alu_Control = alu_dec;
                    if (is_branch && br_taken) begin
                        PC_Write = 1'b1;
                        PC_Src   = 2'd1;
                    end
                    if (is_jal) begin
                        PC_Write        = 1'b1;
                        PC_Src          = 2'd2;
                        Reg_Write       = 1'b1;
                        Result_selector = 2'd3;
                    end
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    addr_src = 1'b1;
                    Imm_Src  = imm_dec;
                    if (is_store) begin
                        mem_write  = 1'b1;
                        store_type = (funct3 == 3'b010);
                    end
                    if (is_load) load_type = (funct3 == 3'b100);
                end
                S_WB: begin
                    Reg_Write = 1'b1;
                    if (is_load) begin
                        Result_selector = 2'd1;
                        load_type       = (funct3 == 3'b100);
                    end
                end
                S_HALT:  Halt = 1'b1;
                default: ;
            endcase
        end
    end

    assign mem.Mem_Req     = mem_req;
    assign mem.Mem_Write   = mem_write;
    assign mem.Address_Src = addr_src;
    assign mem.Store_type  = store_type;
    assign mem.Load_type   = load_type;
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-by-cycle scoreboard bench for multicycle_ctrl: each driven cycle pushes its expected
// control word, which is popped and compared at the following falling edge.
module tb_multicycle_ctrl;
  localparam int PC_W   = 7;
  localparam int END_PC = 84;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [PC_W-1:0] PC;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic            Zero;
  logic            Inst_Write, PC_Write, Reg_Write, Halt, Illegal;
  logic [1:0]      PC_Src, Result_selector;
  logic [2:0]      Imm_Src, Alu_Control, state_dbg;

  multicycle_ctrl_if mem_if ();

  multicycle_ctrl #(.PC_W(PC_W), .END_PC(END_PC)) dut (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .PC              (PC),
    .opcode          (opcode),
    .funct3          (funct3),
    .funct7_5        (funct7_5),
    .Zero            (Zero),
    .mem             (mem_if.master),
    .Inst_Write      (Inst_Write),
    .PC_Write        (PC_Write),
    .PC_Src          (PC_Src),
    .Imm_Src         (Imm_Src),
    .Alu_Control     (Alu_Control),
    .Reg_Write       (Reg_Write),
    .Result_selector (Result_selector),
    .Halt            (Halt),
    .Illegal         (Illegal),
    .state_dbg       (state_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [2:0] st;
    logic       mem_req;
    logic       mem_write;
    logic       addr_src;
    logic       inst_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [2:0] imm;
    logic [2:0] alu;
    logic       reg_write;
    logic [1:0] res_sel;
    logic       store_type;
    logic       load_type;
    logic       halt;
    logic       illegal;
  } ctl_t;

  logic [22:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ctl_t observe();
    ctl_t o;
    o.st         = state_dbg;
    o.mem_req    = mem_if.Mem_Req;
    o.mem_write  = mem_if.Mem_Write;
    o.addr_src   = mem_if.Address_Src;
    o.inst_write = Inst_Write;
    o.pc_write   = PC_Write;
    o.pc_src     = PC_Src;
    o.imm        = Imm_Src;
    o.alu        = Alu_Control;
    o.reg_write  = Reg_Write;
    o.res_sel    = Result_selector;
    o.store_type = mem_if.Store_type;
    o.load_type  = mem_if.Load_type;
    o.halt       = Halt;
    o.illegal    = Illegal;
    return o;
  endfunction

  function automatic ctl_t base(input logic [2:0] st);
    ctl_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic logic [2:0] imm_exp(input logic [6:0] op);
    case (op)
      OP_STORE:  return 3'd1;
      OP_LUI:    return 3'd2;
      OP_BRANCH: return 3'd3;
      OP_JAL:    return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] alu_exp(input logic [6:0] op, input logic [2:0] f3, input logic f75);
    if (op == OP_LUI) return 3'd2;
    if (op == OP_BRANCH) return 3'd3;
    if (op != OP_OP && op != OP_OPIMM) return 3'd0;
    case (f3)
      3'b111:  return 3'd1;
      3'b110:  return 3'd4;
      3'b100:  return 3'd5;
      3'b010:  return 3'd6;
      3'b000:  return (op == OP_OP && f75) ? 3'd3 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  // driver tasks
  task automatic step_check(input ctl_t e, input string tag);
    exp_q.push_back(e);
    @(negedge CLK);
    if (exp_q.size() == 0) check({tag, "/queue"}, 32'd0, 32'd1);
    else check(tag, 32'(observe()), 32'(exp_q.pop_front()));
  endtask

  task automatic step_adv();
    @(posedge CLK);
    #1;
    mem_if.Mem_Ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset(input string tag);
    #2 RST_N = 1'b0;
    #1 check(tag, 32'(observe()), 32'(base(ST_FETCH)));
    @(posedge CLK);
    #1 RST_N = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic z, input int fw, input int mw, input bit abort,
                           input string tag);
    ctl_t e;
    bit ld, st;
    ld = (op == OP_LOAD);
    st = (op == OP_STORE);
    opcode = op; funct3 = f3; funct7_5 = f75; Zero = z;
    for (int i = 0; i <= fw; i++) begin
      e = base(ST_FETCH);
      e.mem_req = 1'b1;
      mem_if.Mem_Ready = (i == fw);
      if (i == fw) begin
        e.inst_write = 1'b1;
        e.pc_write = 1'b1;
      end
      step_check(e, $sformatf("%s/fetch%0d", tag, i));
      step_adv();
    end
    e = base(ST_DECODE);
    e.imm = imm_exp(op);
    step_check(e, {tag, "/decode"});
    step_adv();
    e = base(ST_EXEC);
    e.imm = imm_exp(op);
    e.alu = alu_exp(op, f3, f75);
    if (op == OP_BRANCH && (z ^ f3[0])) begin
      e.pc_write = 1'b1;
      e.pc_src = 2'd1;
    end
    if (op == OP_JAL) begin
      e.pc_write = 1'b1;
      e.pc_src = 2'd2;
      e.reg_write = 1'b1;
      e.res_sel = 2'd3;
    end
    step_check(e, {tag, "/exec"});
    step_adv();
    if (ld || st) begin
      for (int i = 0; i <= mw; i++) begin
        e = base(ST_MEM);
        e.mem_req = 1'b1;
        e.addr_src = 1'b1;
        e.imm = imm_exp(op);
        e.mem_write = st;
        e.store_type = st && (f3 == 3'b010);
        e.load_type = ld && (f3 == 3'b100);
        mem_if.Mem_Ready = (i == mw);
        step_check(e, $sformatf("%s/mem%0d", tag, i));
        if (abort) begin
          do_reset({tag, "/abort"});
          return;
        end
        step_adv();
      end
    end
    if (ld || op == OP_OPIMM || op == OP_OP || op == OP_LUI) begin
      e = base(ST_WB);
      e.reg_write = 1'b1;
      e.res_sel = ld ? 2'd1 : 2'd0;
      e.load_type = ld && (f3 == 3'b100);
      step_check(e, {tag, "/wb"});
      step_adv();
    end
  endtask

  initial begin
    ctl_t e;
    logic [2:0] f3v;
    RST_N = 1'b0;
    PC = '0;
    opcode = '0;
    funct3 = '0;
    funct7_5 = 1'b0;
    Zero = 1'b0;
    mem_if.Mem_Ready = 1'b1;
    #3 check("reset", 32'(observe()), 32'(base(ST_FETCH)));
    @(posedge CLK);
    #1 RST_N = 1'b1;

    PC = 7'd0;
    run_instr(OP_OPIMM, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, "addi");
    PC = 7'd4;
    run_instr(OP_OPIMM, 3'b111, 1'b0, 1'b0, 0, 0, 1'b0, "andi");
    for (int k = 0; k < 8; k++) begin
      f3v = 3'($urandom_range(0, 7));
      PC = 7'($urandom_range(0, 83));
      run_instr(OP_OP, f3v, 1'($urandom_range(0, 1)), 1'b0, 0, 0, 1'b0,
                $sformatf("op_f3_%0d", f3v));
      run_instr(OP_OPIMM, 3'(k), 1'b1, 1'b0, 0, 0, 1'b0, $sformatf("opimm_f3_%0d", k));
    end
    run_instr(OP_OP, 3'b000, 1'b1, 1'b0, 0, 0, 1'b0, "sub");
    PC = 7'd83;
    run_instr(OP_LOAD, 3'b100, 1'b0, 1'b0, 0, 2, 1'b0, "lbu_wait");
    PC = 7'd85;
    run_instr(OP_LOAD, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0, "lw");
    PC = 7'd8;
    run_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 0, 0, 1'b0, "sw");
    run_instr(OP_STORE, 3'b000, 1'b0, 1'b0, 1, 1, 1'b0, "sb_wait");
    run_instr(OP_BRANCH, 3'b000, 1'b0, 1'b1, 0, 0, 1'b0, "beq_z1");
    run_instr(OP_BRANCH, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, "beq_z0");
    run_instr(OP_BRANCH, 3'b001, 1'b0, 1'b1, 0, 0, 1'b0, "bne_z1");
    run_instr(OP_BRANCH, 3'b001, 1'b0, 1'b0, 0, 0, 1'b0, "bne_z0");
    run_instr(OP_JAL, 3'($urandom_range(0, 7)), 1'b0, 1'b0, 0, 0, 1'b0, "jal");
    run_instr(OP_LUI, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0, "lui");
    run_instr(OP_OPIMM, 3'b110, 1'b0, 1'b0, 3, 0, 1'b0, "ori_fetch_wait");

    // End-of-program PC: no request, then terminal HALT
    PC = 7'(END_PC);
    mem_if.Mem_Ready = 1'b1;
    step_check(base(ST_FETCH), "end_pc_fetch");
    step_adv();
    for (int k = 0; k < 4; k++) begin
      e = base(ST_HALT);
      e.halt = 1'b1;
      step_check(e, $sformatf("halt%0d", k));
      step_adv();
    end
    do_reset("reset_from_halt");

    // Unsupported opcode
    PC = 7'd12;
    opcode = 7'b1111111;
    mem_if.Mem_Ready = 1'b1;
    e = base(ST_FETCH);
    e.mem_req = 1'b1;
    e.inst_write = 1'b1;
    e.pc_write = 1'b1;
    step_check(e, "illegal/fetch");
    step_adv();
    step_check(base(ST_DECODE), "illegal/decode");
    step_adv();
    for (int k = 0; k < 3; k++) begin
      e = base(ST_HALT);
      e.halt = 1'b1;
      e.illegal = 1'b1;
      step_check(e, $sformatf("illegal/halt%0d", k));
      step_adv();
    end
    do_reset("reset_from_illegal");

    // Reset mid-MEM of a store, then a clean restart
    PC = 7'd16;
    run_instr(OP_STORE, 3'b010, 1'b0, 1'b0, 0, 2, 1'b1, "sw_abort");
    run_instr(OP_OPIMM, 3'b100, 1'b0, 1'b0, 0, 0, 1'b0, "xori_after_reset");

    if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end");
    $fatal(1);
  end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Parametrised multicycle control unit for the RV32I-subset core. It replaces the fixed five-state controller with a state machine that has:
- memory wait states via a request/ready handshake;
- additional instruction classes (R-type ALU, BEQ/BNE branches, JAL);
- a configurable PC width and end-of-program address;
- a terminal HALT state with a sticky illegal-instruction flag.

It sits between the instruction register and the datapath and drives every mux select and write enable in the core.

## Interface
- PC_W, 7, width of the PC input
- END_PC, 84, PC value at which fetch stops and the unit enters HALT
- CLK  in  1  rising-edge clock, sole clock
- RST_N  in  1  asynchronous active-low reset
- PC  in  PC_W  current PC from datapath
- opcode  in  7  instruction register [6:0]
- funct3  in  3  instruction register [14:12]
- funct7_5  in  1  instruction register [30]
- Zero  in  1  ALU zero flag (valid in EXEC)
- Mem_Ready  in  1  memory completes the current request this cycle
- Mem_Req  out  1  memory request active
- Mem_Write  out  1  store strobe, only valid with Mem_Req
- Address_Src  out  1  0 = PC, 1 = ALU result
- Inst_Write  out  1  load instruction register
- PC_Write  out  1  update PC
- PC_Src  out  2  0 = PC+4, 1 = branch target, 2 = JAL target
- Imm_Src  out  3  0 = I, 1 = S, 2 = U, 3 = B, 4 = J
- Alu_Control  out  3  0 add, 1 and, 2 pass-B, 3 sub, 4 or, 5 xor, 6 slt
- Reg_Write  out  1  register-file write enable
- Result_selector  out  2  0 = ALU, 1 = memory data, 3 = link (PC+4 of current instruction)
- Store_type  out  1  1 = sw, 0 = sb
- Load_type  out  1  1 = lbu, 0 = lw
- Halt  out  1  unit is in HALT
- Illegal  out  1  sticky: HALT was entered on an unsupported opcode

## Operation

States: FETCH, DECODE, EXEC, MEM, WB, HALT.

Supported opcodes:
- LOAD 0000011
- STORE 0100011
- OPIMM 0010011
- OP 0110011
- LUI 0110111
- BRANCH 1100011
- JAL 1101111

Outputs are combinational from state and decoded fields. Every output not listed for a state is 0.

- **FETCH**
  - If PC == END_PC: Mem_Req = 0, next state HALT.
  - Otherwise: Mem_Req = 1, Address_Src = 0, and the unit stays in FETCH until Mem_Ready.
  - In the Mem_Ready cycle: Inst_Write = 1, PC_Write = 1, PC_Src = 0, next state DECODE.
- **DECODE**
  - Imm_Src is set by opcode.
  - Unsupported opcode: next state HALT, Illegal set.
  - Otherwise: next state EXEC.
- **EXEC**
  - Imm_Src is held from DECODE.
  - Alu_Control decode:
    - OPIMM/OP by funct3: 000 → add, or sub when OP and funct7_5 = 1; 111 → and; 110 → or; 100 → xor; 010 → slt.
    - LUI → pass-B.
    - LOAD/STORE → add.
    - BRANCH → sub.
  - Next state:
    - LOAD/STORE → MEM.
    - OPIMM/OP/LUI → WB.
    - BRANCH: taken = Zero XOR funct3[0]. When taken, PC_Write = 1 and PC_Src = 1. Next state FETCH in either case.
    - JAL: PC_Write = 1, PC_Src = 2, Reg_Write = 1, Result_selector = 3. Next state FETCH.
  - Any funct3 not listed for OPIMM/OP decodes to add; it is not flagged illegal.
- **MEM**
  - Mem_Req = 1, Address_Src = 1, Alu_Control = add.
  - STORE: Mem_Write = 1, Store_type = (funct3 == 010).
  - LOAD: Load_type = (funct3 == 100).
  - Signals are held until Mem_Ready. In the Mem_Ready cycle, STORE goes to FETCH and LOAD goes to WB.
- **WB**
  - Reg_Write = 1.
  - Result_selector = 1 for LOAD, 0 otherwise.
  - Load_type is held for LOAD.
  - Next state FETCH.
- **HALT**
  - Halt = 1; all strobes 0.
  - Terminal; only RST_N exits.

## Timing
- Reset (RST_N = 0, asynchronous):
  - State goes to FETCH and Illegal clears.
  - All outputs are forced to 0 while RST_N is low, including Mem_Req.
  - After release, the first FETCH request appears in the same cycle RST_N is high.
- Cycles per instruction, zero-wait memory:
  - OPIMM/OP/LUI: 4
  - LOAD: 5
  - STORE: 4
  - BRANCH/JAL: 3
  - Each cycle with Mem_Ready = 0 in FETCH or MEM adds one cycle.
- Mem_Ready is ignored outside FETCH and MEM. Mem_Req and Mem_Write stay stable while waiting.
- opcode, funct3 and funct7_5 are sampled from DECODE onward. They must stay stable until the next Inst_Write; the instruction register guarantees this.
- The END_PC check is evaluated in every FETCH cycle. A PC equal to END_PC issues no request.
- Reset asserted mid-MEM aborts the access immediately: Mem_Req and Mem_Write drop without waiting for Mem_Ready.

## Test plan
- **addi / andi**: addi (opcode 0010011, funct3 000) then andi (funct3 111), Mem_Ready tied 1 → 4 cycles each; Alu_Control 0 then 1; Reg_Write = 1 only in WB; Inst_Write + PC_Write pulse once per instruction.
- **lbu with wait states**: lbu (0000011, funct3 100) with Mem_Ready low for 2 cycles in MEM → MEM lasts 3 cycles with Address_Src = 1, Load_type = 1; WB has Result_selector = 1; total 7 cycles.
- **sw**: sw (0100011, funct3 010) → MEM has Mem_Write = 1, Store_type = 1, Imm_Src = 1 from DECODE onward; no Reg_Write; 4 cycles.
- **beq / bne**:
  - beq, Zero = 1 → EXEC has PC_Write = 1, PC_Src = 1; 3 cycles.
  - bne, Zero = 1 → PC_Write = 0 in EXEC.
  - jal → PC_Src = 2, Reg_Write = 1, Result_selector = 3.
- **Halt and illegal**:
  - PC = 84 in FETCH → no Mem_Req; Halt = 1 next cycle and stays set under further clocks.
  - Separate run with opcode 1111111 → HALT with Illegal = 1.
- **Reset**: assert RST_N low mid-MEM of a store → Mem_Req and Mem_Write go to 0 with no clock edge; after release the unit starts in FETCH with Illegal = 0.
